// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-channel arbiter.
// The state encoding is one-hot; burst-type codes are shared with the masters.
package axi_rd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_AR_FWD  = 3'b010,
        ST_R_BURST = 3'b100
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Upper bound on NUM_M; one-hot grants are widened to this before encoding.
    localparam int MAX_M = 8;

    function automatic logic [2:0] oh_to_idx(input logic [MAX_M-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_M; k++) begin
            if (oh[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address/data bundle for N lanes: AR fields and handshakes are per lane,
// R payload (rid/rdata/rlast) is shared, rvalid/rready are per lane.
interface axi_rd_arbiter_if #(
    parameter int N      = 1,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N*ID_W-1:0]   arid;
    logic [N*ADDR_W-1:0] araddr;
    logic [N*8-1:0]      arlen;
    logic [N*3-1:0]      arsize;
    logic [N*2-1:0]      arburst;
    logic [N-1:0]        arvalid;
    logic [N-1:0]        arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rlast, rvalid
    );

endinterface

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr_i,
// wrapping around; returns a one-hot grant and an any-request flag.
module axi_rd_arbiter_rr_pick #(
    parameter int NUM_M = 4,
    parameter int PTR_W = 2
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic             any_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_M);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read slave among NUM_M masters, one burst at a time, with
// round-robin selection and beat-count checking against the latched ARLEN.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_M  = 4,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    axi_rd_arbiter_if.slave    m,
    axi_rd_arbiter_if.master   s,
    output logic [NUM_M-1:0]   grant,
    output logic               busy,
    output logic               len_err,
    output logic               stray_r
);

    localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    state_e             state_q, state_d;
    logic [NUM_M-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         exp_len_q, exp_len_d;
    logic               err_seen_q, err_seen_d;
    logic               len_err_q, len_err_d;
    logic               stray_q, stray_d;

    logic [NUM_M-1:0]   pick_gnt;
    logic               pick_any;
    logic               in_ar;
    logic               in_r;
    logic               beat;
    logic               len_mismatch;
    logic [7:0]         sel_arlen;

    axi_rd_arbiter_rr_pick #(
        .NUM_M (NUM_M),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i    (m.arvalid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_gnt),
        .any_o    (pick_any)
    );

    // Handshake routing is forced off while reset is held so a mid-burst reset
    // never leaks a valid/ready through the reset cycle itself.
    assign in_ar = !reset && (state_q == ST_AR_FWD);
    assign in_r  = !reset && (state_q == ST_R_BURST);

    assign sel_arlen  = m.arlen[int'(gidx_q)*8 +: 8];
    assign s.arid     = m.arid[int'(gidx_q)*ID_W +: ID_W];
    assign s.araddr   = m.araddr[int'(gidx_q)*ADDR_W +: ADDR_W];
    assign s.arlen    = sel_arlen;
    assign s.arsize   = m.arsize[int'(gidx_q)*3 +: 3];
    assign s.arburst  = m.arburst[int'(gidx_q)*2 +: 2];
    assign s.arvalid[0] = in_ar && m.arvalid[gidx_q];
    assign s.rready[0]  = in_r && m.rready[gidx_q];

    assign m.rid   = s.rid;
    assign m.rdata = s.rdata;
    assign m.rlast = s.rlast;

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_lane
            assign m.arready[gi] = in_ar && grant_q[gi] && s.arready[0];
            assign m.rvalid[gi]  = in_r && grant_q[gi] && s.rvalid[0];
        end
    endgenerate

    assign beat = s.rvalid[0] && s.rready[0];

    // Early rlast, or the expected final beat arriving without rlast.
    assign len_mismatch = s.rlast ? (beat_cnt_q != exp_len_q)
                                  : (beat_cnt_q == exp_len_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        exp_len_d  = exp_len_q;
        err_seen_d = err_seen_q;
        len_err_d  = 1'b0;
        stray_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stray_d = s.rvalid[0];
                if (pick_any) begin
                    grant_d = pick_gnt;
                    gidx_d  = PTR_W'(oh_to_idx(MAX_M'(pick_gnt)));
                    state_d = ST_AR_FWD;
                end
            end
            ST_AR_FWD: begin
                stray_d = s.rvalid[0];
                if (s.arvalid[0] && s.arready[0]) begin
                    exp_len_d  = sel_arlen;
                    beat_cnt_d = '0;
                    err_seen_d = 1'b0;
                    state_d    = ST_R_BURST;
                end
            end
            ST_R_BURST: begin
                if (beat) begin
                    if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (len_mismatch && !err_seen_q) begin
                        len_err_d  = 1'b1;
                        err_seen_d = 1'b1;
                    end
                    if (s.rlast) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = (gidx_q == PTR_W'(NUM_M - 1)) ? '0 : gidx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            exp_len_q  <= '0;
            err_seen_q <= 1'b0;
            len_err_q  <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            exp_len_q  <= exp_len_d;
            err_seen_q <= err_seen_d;
            len_err_q  <= len_err_d;
            stray_q    <= stray_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign len_err = len_err_q;
    assign stray_r = stray_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized
// multi-master traffic checked against a transaction-level round-robin model.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int NUM_M  = 4;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NUM_M-1:0] grant;
    logic             busy;
    logic             len_err;
    logic             stray_r;

    int checks = 0;
    int errors = 0;

    axi_rd_arbiter_if #(.N(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif();
    axi_rd_arbiter_if #(.N(1), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif();

    axi_rd_arbiter #(
        .NUM_M (NUM_M),
        .ID_W  (ID_W),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .m      (mif),
        .s      (sif),
        .grant  (grant),
        .busy   (busy),
        .len_err(len_err),
        .stray_r(stray_r)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mif.arid    = '0;
        mif.araddr  = '0;
        mif.arlen   = '0;
        mif.arsize  = '0;
        mif.arburst = {NUM_M{BURST_INCR}};
        mif.arvalid = '0;
        mif.rready  = '1;
        sif.arready = '0;
        sif.rid     = '0;
        sif.rdata   = '0;
        sif.rlast   = 1'b0;
        sif.rvalid  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int mi, input logic [7:0] len,
                           input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id);
        mif.arid[mi*ID_W +: ID_W]       = id;
        mif.araddr[mi*ADDR_W +: ADDR_W] = addr;
        mif.arlen[mi*8 +: 8]            = len;
        mif.arsize[mi*3 +: 3]           = 3'd2;
        mif.arburst[mi*2 +: 2]          = BURST_INCR;
        mif.arvalid[mi]                 = 1'b1;
    endtask

    // Lets the slave accept the next AR; returns the granted master, -1 on timeout.
    task automatic wait_ar(output int owner);
        owner = -1;
        sif.arready = 1'b1;
        for (int c = 0; c < 20 && owner < 0; c++) begin
            #1;
            if (sif.arvalid[0] && sif.arready[0]) begin
                for (int i = 0; i < NUM_M; i++) if (grant[i]) owner = i;
                if (owner < 0) owner = NUM_M;
            end
            tick();
        end
        sif.arready = 1'b0;
        if (owner >= 0 && owner < NUM_M) mif.arvalid[owner] = 1'b0;
        if (owner < 0) begin
            checks++;
            errors++;
            $display("FAIL ar_timeout got=no_handshake exp=handshake");
        end
    endtask

    task automatic send_beats(input int n, input int rlast_at);
        for (int b = 0; b < n; b++) begin
            sif.rvalid = 1'b1;
            sif.rdata  = $urandom;
            sif.rlast  = (b == rlast_at);
            tick();
        end
        sif.rvalid = 1'b0;
        sif.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got grant=%b busy=%b exp grant=0 busy=0", grant, busy);
        end
        checks++;
        if (mif.arready !== '0 || mif.rvalid !== '0 || sif.arvalid !== 1'b0 || sif.rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshakes got arready=%b rvalid=%b s_arvalid=%b s_rready=%b exp all 0",
                     mif.arready, mif.rvalid, sif.arvalid, sif.rready);
        end
        checks++;
        if (len_err !== 1'b0 || stray_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got len_err=%b stray_r=%b exp 0 0", len_err, stray_r);
        end
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] d;
        int owner;
        set_req(0, 8'd3, 32'h1000_0040, 4'h5);
        sif.arready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || sif.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_arb_latency got busy=%b s_arvalid=%b exp 0 0", busy, sif.arvalid);
        end
        tick();
        #1;
        checks++;
        if (grant !== 4'b0001 || mif.arready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant got grant=%b arready=%b exp 0001 0001", grant, mif.arready);
        end
        checks++;
        if (sif.arvalid !== 1'b1 || sif.araddr !== 32'h1000_0040 || sif.arlen !== 8'd3 || sif.arid !== 4'h5) begin
            errors++;
            $display("FAIL single_ar_fwd got v=%b addr=%h len=%0d id=%h exp 1 10000040 3 5",
                     sif.arvalid, sif.araddr, sif.arlen, sif.arid);
        end
        tick();
        mif.arvalid[0] = 1'b0;
        sif.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            sif.rvalid = 1'b1;
            sif.rdata  = d;
            sif.rlast  = (b == 3);
            sif.rid    = 4'h5;
            #1;
            checks++;
            if (mif.rvalid !== 4'b0001 || mif.rdata !== d || mif.rlast !== (b == 3) || sif.rready !== 1'b1) begin
                errors++;
                $display("FAIL single_beat%0d got rvalid=%b data=%h last=%b s_rready=%b exp 0001 %h %b 1",
                         b, mif.rvalid, mif.rdata, mif.rlast, sif.rready, d, (b == 3));
            end
            tick();
        end
        sif.rvalid = 1'b0;
        sif.rlast  = 1'b0;
        #1;
        checks++;
        if (len_err !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL single_done got len_err=%b busy=%b grant=%b exp 0 0 0", len_err, busy, grant);
        end
        // rr_ptr should now be 1: with masters 0 and 1 pending, 1 wins.
        set_req(0, 8'd0, 32'h2000_0000, 4'h1);
        set_req(1, 8'd0, 32'h2100_0000, 4'h2);
        wait_ar(owner);
        checks++;
        if (owner !== 1) begin
            errors++;
            $display("FAIL single_rr_ptr got owner=%0d exp 1", owner);
        end
        send_beats(1, 0);
        wait_ar(owner);
        send_beats(1, 0);
    endtask

    task automatic test_rr_order();
        int owner;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 8'd1, 32'h3000_0000 + 32'(i * 16), 4'(i));
        for (int k = 0; k < 3; k++) begin
            wait_ar(owner);
            checks++;
            if (owner !== k) begin
                errors++;
                $display("FAIL rr_order_%0d got owner=%0d exp %0d", k, owner, k);
            end
            send_beats(2, 1);
            #1;
            checks++;
            if (busy !== 1'b0 || grant !== '0) begin
                errors++;
                $display("FAIL rr_gap_idle_%0d got busy=%b grant=%b exp 0 0", k, busy, grant);
            end
            if (k < 2) begin
                tick();
                checks++;
                if (busy !== 1'b1 || sif.arvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_gap_next_%0d got busy=%b s_arvalid=%b exp 1 1", k, busy, sif.arvalid);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] d[4];
        logic [DATA_W-1:0] got[$];
        int owner;
        int b;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        set_req(1, 8'd3, 32'h4000_0000, 4'h9);
        wait_ar(owner);
        checks++;
        if (owner !== 1) begin
            errors++;
            $display("FAIL stall_owner got %0d exp 1", owner);
        end
        b = 0;
        for (int cyc = 0; cyc < 30 && b < 4; cyc++) begin
            sif.rvalid = 1'b1;
            sif.rdata  = d[b];
            sif.rlast  = (b == 3);
            mif.rready[1] = !(cyc >= 1 && cyc <= 5);
            #1;
            if (!mif.rready[1]) begin
                checks++;
                if (sif.rready !== 1'b0 || mif.rvalid[1] !== 1'b1 || mif.rdata !== d[b]) begin
                    errors++;
                    $display("FAIL stall_cyc%0d got s_rready=%b rvalid1=%b data=%h exp 0 1 %h",
                             cyc, sif.rready, mif.rvalid[1], mif.rdata, d[b]);
                end
            end
            if (mif.rvalid[1] && mif.rready[1]) begin
                got.push_back(mif.rdata);
                b++;
            end
            tick();
        end
        sif.rvalid = 1'b0;
        sif.rlast  = 1'b0;
        mif.rready = '1;
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL stall_count got %0d exp 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== d[i]) begin
                    errors++;
                    $display("FAIL stall_data%0d got %h exp %h", i, got[i], d[i]);
                end
            end
        end
    endtask

    task automatic test_len_err();
        int owner;
        int pulses;
        int first;
        set_req(2, 8'd2, 32'h5000_0000, 4'h3);
        wait_ar(owner);
        send_beats(2, 1);
        checks++;
        if (len_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len_early got len_err=%b busy=%b exp 1 0", len_err, busy);
        end
        tick();
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_early_width got len_err=%b exp 0", len_err);
        end
        set_req(3, 8'd2, 32'h5100_0000, 4'h4);
        wait_ar(owner);
        pulses = 0;
        first  = -1;
        for (int c = 0; c < 7; c++) begin
            sif.rvalid = (c < 5);
            sif.rdata  = $urandom;
            sif.rlast  = (c == 4);
            tick();
            if (len_err === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        sif.rvalid = 1'b0;
        sif.rlast  = 1'b0;
        checks++;
        if (pulses != 1 || first != 2) begin
            errors++;
            $display("FAIL len_missing_last got pulses=%0d at=%0d exp 1 at 2", pulses, first);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL len_missing_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_stray();
        sif.rvalid = 1'b1;
        sif.rdata  = $urandom;
        #1;
        checks++;
        if (mif.rvalid !== '0 || sif.rready !== 1'b0) begin
            errors++;
            $display("FAIL stray_route got rvalid=%b s_rready=%b exp 0 0", mif.rvalid, sif.rready);
        end
        tick();
        sif.rvalid = 1'b0;
        checks++;
        if (stray_r !== 1'b1) begin
            errors++;
            $display("FAIL stray_pulse got %b exp 1", stray_r);
        end
        tick();
        checks++;
        if (stray_r !== 1'b0) begin
            errors++;
            $display("FAIL stray_clear got %b exp 0", stray_r);
        end
    endtask

    task automatic test_reset_mid();
        int owner;
        set_req(1, 8'd0, 32'h6000_0000, 4'h6);
        wait_ar(owner);
        send_beats(1, 0);
        set_req(2, 8'd7, 32'h6100_0000, 4'h7);
        wait_ar(owner);
        sif.rvalid = 1'b1;
        sif.rdata  = $urandom;
        tick();
        sif.rdata  = $urandom;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        sif.rvalid = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state got grant=%b busy=%b exp 0 0", grant, busy);
        end
        checks++;
        if (mif.arready !== '0 || mif.rvalid !== '0 || sif.arvalid !== 1'b0 || sif.rready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_handshakes got arready=%b rvalid=%b s_arvalid=%b s_rready=%b exp 0",
                     mif.arready, mif.rvalid, sif.arvalid, sif.rready);
        end
        set_req(1, 8'd0, 32'h6200_0000, 4'h1);
        set_req(3, 8'd0, 32'h6300_0000, 4'h3);
        wait_ar(owner);
        checks++;
        if (owner !== 1) begin
            errors++;
            $display("FAIL rstmid_rr_ptr got owner=%0d exp 1", owner);
        end
        send_beats(1, 0);
        wait_ar(owner);
        send_beats(1, 0);
    endtask

    task automatic test_random();
        int rem[NUM_M];
        logic [7:0] blen[NUM_M];
        logic [ADDR_W-1:0] baddr[NUM_M];
        logic [ID_W-1:0] bid[NUM_M];
        int ptr, owner, s_left, bursts, total, cyc, pick, pending;
        logic beat_taken, expect_idle;
        logic [DATA_W-1:0] cur_data;
        logic [ID_W-1:0] cur_id;
        logic [NUM_M-1:0] exp_rv;
        logic exp_rr;
        do_reset();
        ptr = 0; owner = 0; s_left = 0; bursts = 0; total = 0; cyc = 0;
        beat_taken = 1'b0; expect_idle = 1'b0; cur_data = '0; cur_id = '0;
        for (int i = 0; i < NUM_M; i++) begin
            rem[i]   = 3 + int'($urandom_range(0, 2));
            total   += rem[i];
            blen[i]  = 8'($urandom_range(0, 7));
            baddr[i] = $urandom;
            bid[i]   = ID_W'($urandom);
        end
        pending = total;
        while ((pending > 0 || s_left > 0) && cyc < 5000) begin
            cyc++;
            if (beat_taken) sif.rvalid = 1'b0;
            beat_taken = 1'b0;
            for (int i = 0; i < NUM_M; i++) begin
                if (rem[i] > 0) set_req(i, blen[i], baddr[i], bid[i]);
                else mif.arvalid[i] = 1'b0;
            end
            mif.rready  = NUM_M'($urandom) | NUM_M'($urandom);
            sif.arready = 1'($urandom_range(0, 1));
            if (s_left > 0 && !sif.rvalid[0] && $urandom_range(0, 3) != 0) begin
                sif.rvalid = 1'b1;
                sif.rdata  = $urandom;
                sif.rlast  = (s_left == 1);
                sif.rid    = cur_id;
                cur_data   = sif.rdata;
            end
            #1;
            if (expect_idle) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_gap cyc=%0d got busy=%b exp 0", cyc, busy);
                end
                expect_idle = 1'b0;
            end
            exp_rv = '0;
            if (s_left > 0 && sif.rvalid[0]) exp_rv[owner] = 1'b1;
            exp_rr = (s_left > 0) && mif.rready[owner];
            checks++;
            if (mif.rvalid !== exp_rv || sif.rready[0] !== exp_rr) begin
                errors++;
                $display("FAIL rand_route cyc=%0d got rvalid=%b s_rready=%b exp %b %b",
                         cyc, mif.rvalid, sif.rready, exp_rv, exp_rr);
            end
            checks++;
            if (len_err !== 1'b0 || stray_r !== 1'b0) begin
                errors++;
                $display("FAIL rand_flags cyc=%0d got len_err=%b stray_r=%b exp 0 0", cyc, len_err, stray_r);
            end
            if (sif.arvalid[0] && sif.arready[0]) begin
                pick = -1;
                for (int k = 0; k < NUM_M; k++) begin
                    if (pick < 0 && rem[(ptr + k) % NUM_M] > 0) pick = (ptr + k) % NUM_M;
                end
                checks++;
                if (pick < 0 || s_left != 0 || grant !== NUM_M'(1 << pick) || mif.arready !== NUM_M'(1 << pick)
                    || sif.araddr !== baddr[pick] || sif.arlen !== blen[pick] || sif.arid !== bid[pick]) begin
                    errors++;
                    $display("FAIL rand_ar cyc=%0d got grant=%b arready=%b addr=%h len=%0d exp master %0d",
                             cyc, grant, mif.arready, sif.araddr, sif.arlen, pick);
                end
                if (pick >= 0) begin
                    owner    = pick;
                    cur_id   = bid[pick];
                    s_left   = int'(blen[pick]) + 1;
                    rem[pick]--;
                    pending--;
                    ptr      = (pick + 1) % NUM_M;
                    bursts++;
                    blen[pick]  = 8'($urandom_range(0, 7));
                    baddr[pick] = $urandom;
                    bid[pick]   = ID_W'($urandom);
                end
            end
            if (sif.rvalid[0] && sif.rready[0] && s_left > 0) begin
                checks++;
                if (mif.rdata !== cur_data || mif.rlast !== (s_left == 1) || mif.rid !== cur_id) begin
                    errors++;
                    $display("FAIL rand_beat cyc=%0d got data=%h last=%b id=%h exp %h %b %h",
                             cyc, mif.rdata, mif.rlast, mif.rid, cur_data, (s_left == 1), cur_id);
                end
                s_left--;
                beat_taken = 1'b1;
                if (s_left == 0) expect_idle = 1'b1;
            end
            tick();
        end
        sif.rvalid  = 1'b0;
        mif.arvalid = '0;
        mif.rready  = '1;
        checks++;
        if (bursts != total || s_left != 0) begin
            errors++;
            $display("FAIL rand_complete got bursts=%0d left=%0d exp %0d 0", bursts, s_left, total);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_rr_order();
        test_stall();
        test_len_err();
        test_stray();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read slave (the out-FIFO read FSM and its datapath) among NUM_M AXI4 read masters.
- Round-robin arbitration with one outstanding burst at a time; the grant is held until the slave returns the final beat (rlast).
- Tracks beat count against the latched arlen and flags protocol mismatches, which gives the slave FSM a single well-behaved requester.

Parameters:
- NUM_M, 4, number of requesting masters (2..8).
- ID_W, 4, AXI ID width.
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_arid  in  NUM_M*ID_W  per-master ARID, packed, master i at [i*ID_W +: ID_W]
- m_araddr  in  NUM_M*ADDR_W  per-master ARADDR, packed
- m_arlen  in  NUM_M*8  per-master ARLEN, packed
- m_arsize  in  NUM_M*3  per-master ARSIZE, packed
- m_arburst  in  NUM_M*2  per-master ARBURST, packed
- m_arvalid  in  NUM_M  per-master ARVALID
- m_arready  out  NUM_M  per-master ARREADY
- m_rid  out  ID_W  RID, broadcast to all masters
- m_rdata  out  DATA_W  RDATA, broadcast to all masters
- m_rlast  out  1  RLAST, broadcast to all masters
- m_rvalid  out  NUM_M  per-master RVALID
- m_rready  in  NUM_M  per-master RREADY
- s_arid, s_araddr, s_arlen, s_arsize, s_arburst  out  ID_W/ADDR_W/8/3/2  AR channel to the slave
- s_arvalid  out  1  ARVALID to the slave
- s_arready  in  1  ARREADY from the slave
- s_rid  in  ID_W  RID from the slave
- s_rdata  in  DATA_W  RDATA from the slave
- s_rlast  in  1  RLAST from the slave
- s_rvalid  in  1  RVALID from the slave
- s_rready  out  1  RREADY to the slave
- grant  out  NUM_M  one-hot, registered; current owner
- busy  out  1  high whenever state != IDLE
- len_err  out  1  one-cycle pulse on beat/rlast mismatch
- stray_r  out  1  one-cycle pulse on s_rvalid while IDLE

Behaviour:
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, exp_len=0.
  - All m_arready, m_rvalid, s_arvalid, s_rready, len_err and stray_r are 0.
- One-hot states: IDLE, AR_FWD, R_BURST.
- IDLE:
  - Select the first asserted m_arvalid, searching from rr_ptr upward with wrap-around.
  - On any request: grant<=that master, next state AR_FWD. Arbitration costs 1 cycle of latency.
  - No request: stay in IDLE.
- AR_FWD:
  - s_ar* is the combinational mux of the granted master's AR fields.
  - s_arvalid=m_arvalid[g]; m_arready[g]=s_arready; every other m_arready is 0.
  - On s_arvalid&&s_arready: exp_len<=granted arlen, beat_cnt<=0, next state R_BURST.
  - If the granted master drops arvalid (AXI violation), hold the grant and wait.
- R_BURST:
  - m_rvalid[g]=s_rvalid; s_rready=m_rready[g]; m_rid/m_rdata/m_rlast follow s_*.
  - Every other m_rvalid is 0.
  - On each beat (s_rvalid&&s_rready): beat_cnt++ (8-bit).
  - On a beat with s_rlast: next state IDLE; grant<=0; rr_ptr<=(g+1) mod NUM_M.
- len_err pulses when either of these occurs:
  - s_rlast arrives on a beat with beat_cnt!=exp_len.
  - A beat arrives with beat_cnt==exp_len and s_rlast=0. The burst continues to the real rlast; the pulse fires once per burst.
- stray_r pulses when s_rvalid is asserted in IDLE or AR_FWD. s_rready stays 0 in those states.
- Simultaneous requests: resolve strictly by rr_ptr order. A master that keeps arvalid high after completing waits for all other pending masters.
- A request arriving in the same cycle as the rlast beat is not seen until the next IDLE cycle. Minimum gap between bursts: 1 IDLE cycle.
- Reset mid-burst: return to IDLE immediately with all outputs at reset values. The partial burst is abandoned.
- exp_len=255 (256 beats): beat_cnt reaches 255 without wrapping; the rlast check applies as normal.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=3'b001, AR_FWD=3'b010, R_BURST=3'b100).
  - AXI burst type constants (FIXED/INCR/WRAP).
- One sub-module is natural: rr_pick, a combinational round-robin priority picker. Inputs: req[NUM_M] and rr_ptr. Outputs: a one-hot grant and an any-request flag.

Test Plan:
- Single master 0, arlen=3, slave returns 4 beats with rlast on beat 4 → one AR handshake, 4 beats delivered to master 0 only; len_err=0; rr_ptr=1 afterwards.
- Masters 0, 1 and 2 all raise arvalid at once with rr_ptr=0 → grants in order 0,1,2. Each grant is held through its rlast, with 1 IDLE cycle between bursts.
- Master 1 holds rready=0 for 5 cycles mid-burst → s_rready=0 for those cycles; slave data is stable; no beat lost or duplicated.
- arlen=2 but the slave asserts rlast on beat 2 → len_err pulses for 1 cycle and the arbiter returns to IDLE. Separately, no rlast on beat 3 → len_err pulses once.
- s_rvalid=1 while IDLE → stray_r pulses; no m_rvalid asserted; s_rready=0.
- Reset asserted during beat 2 of an 8-beat burst → the next cycle shows grant=0, busy=0, all valid/ready=0. A new request after reset is granted normally from rr_ptr=0.
